// File: rtl/awgn_clt_multi.sv
`default_nettype none
// ============================================================================
// Module  : awgn_clt_multi
// Brief   : NUM_CH taus88 URNGs -> 4-term CLT sum -> Q8.8 sigma scale ->
//           round/saturate, delivered on a valid/ready stream.
// Revision: 1.0  initial release
// ============================================================================
module awgn_clt_multi #(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      seed_load,
    input  logic [NUM_CH*96-1:0]      seed_data,
    input  logic [15:0]               scale,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [NUM_CH*OUT_W-1:0]   out_data,
    output logic [31:0]               sample_cnt
);

    localparam logic [OUT_W-1:0]   C_OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   C_OUT_MIN = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic signed [27:0] C_SAT_MAX = 28'(C_OUT_MAX);
    localparam logic signed [27:0] C_SAT_MIN = -C_SAT_MAX;

    logic w_stall;
    logic w_load;
    logic r_v0, r_v1, r_v2;

    assign w_stall = out_valid & ~out_ready;
    // seed_load flushes exactly like reset, overriding any stall
    assign w_load  = reset | seed_load;

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_v0      <= en;
            r_v1      <= r_v0;
            r_v2      <= r_v1;
            out_valid <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= 32'd0;
        end else if (!seed_load && out_valid && out_ready) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0]        w_sd1, w_sd2, w_sd3;
        logic [31:0]        w_n1, w_n2, w_n3;
        logic [31:0]        r_z1, r_z2, r_z3, r_u;
        logic [9:0]         w_sum;
        logic signed [10:0] r_s;
        logic signed [27:0] w_prod, r_p, w_rnd;
        logic [OUT_W-1:0]   r_out;

        // Forcing these bits keeps each component above the taus88 minimum
        assign w_sd1 = seed_data[c*96 +: 32]      | 32'h0000_0002;
        assign w_sd2 = seed_data[c*96 + 32 +: 32] | 32'h0000_0008;
        assign w_sd3 = seed_data[c*96 + 64 +: 32] | 32'h0000_0010;

        assign w_n1 = ((r_z1 & 32'hFFFF_FFFE) << 12) ^ (((r_z1 << 13) ^ r_z1) >> 19);
        assign w_n2 = ((r_z2 & 32'hFFFF_FFF8) << 4)  ^ (((r_z2 << 2)  ^ r_z2) >> 25);
        assign w_n3 = ((r_z3 & 32'hFFFF_FFF0) << 17) ^ (((r_z3 << 3)  ^ r_z3) >> 11);

        assign w_sum  = {2'b00, r_u[7:0]} + {2'b00, r_u[15:8]}
                      + {2'b00, r_u[23:16]} + {2'b00, r_u[31:24]};
        assign w_prod = $signed({{17{r_s[10]}}, r_s}) * $signed({12'd0, scale});
        assign w_rnd  = (r_p + 28'sd128) >>> 8;

        always_ff @(posedge clk) begin
            if (w_load) begin
                r_z1  <= w_sd1;
                r_z2  <= w_sd2;
                r_z3  <= w_sd3;
                r_u   <= 32'd0;
                r_s   <= 11'sd0;
                r_p   <= 28'sd0;
                r_out <= '0;
            end else if (!w_stall) begin
                if (en) begin
                    r_z1 <= w_n1;
                    r_z2 <= w_n2;
                    r_z3 <= w_n3;
                    r_u  <= w_n1 ^ w_n2 ^ w_n3;
                end
                r_s <= $signed({1'b0, w_sum}) - 11'sd510;
                r_p <= w_prod;
                if (w_rnd > C_SAT_MAX) begin
                    r_out <= C_OUT_MAX;
                end else if (w_rnd < C_SAT_MIN) begin
                    r_out <= C_OUT_MIN;
                end else begin
                    r_out <= w_rnd[OUT_W-1:0];
                end
            end
        end

        assign out_data[c*OUT_W +: OUT_W] = r_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_awgn_clt_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_awgn_clt_multi
// Brief   : Randomised bench for awgn_clt_multi against a taus88+CLT model.
// Revision: 1.0  initial release
// ============================================================================
module tb_awgn_clt_multi;

    localparam int NUM_CH = 2;
    localparam int OUT_W  = 17;
    localparam longint C_MAXV = (longint'(1) << (OUT_W - 1)) - 1;

    logic                    clk = 1'b0;
    logic                    reset, en, seed_load, out_ready, out_valid;
    logic [NUM_CH*96-1:0]    seed_data;
    logic [15:0]             scale;
    logic [NUM_CH*OUT_W-1:0] out_data;
    logic [31:0]             sample_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned m_z1 [NUM_CH];
    int unsigned m_z2 [NUM_CH];
    int unsigned m_z3 [NUM_CH];

    int                      acc;
    int                      issued;
    int                      iter;
    int                      first_valid;
    bit                      prev_stall;
    logic [NUM_CH*OUT_W-1:0] prev_data;

    awgn_clt_multi #(.NUM_CH(NUM_CH), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .seed_load  (seed_load),
        .seed_data  (seed_data),
        .scale      (scale),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned taus1(input int unsigned z);
        return ((z & 32'hFFFF_FFFE) << 12) ^ (((z << 13) ^ z) >> 19);
    endfunction
    function automatic int unsigned taus2(input int unsigned z);
        return ((z & 32'hFFFF_FFF8) << 4) ^ (((z << 2) ^ z) >> 25);
    endfunction
    function automatic int unsigned taus3(input int unsigned z);
        return ((z & 32'hFFFF_FFF0) << 17) ^ (((z << 3) ^ z) >> 11);
    endfunction

    task automatic model_load(input logic [NUM_CH*96-1:0] sd);
        for (int c = 0; c < NUM_CH; c++) begin
            m_z1[c] = sd[c*96 +: 32]      | 32'h2;
            m_z2[c] = sd[c*96 + 32 +: 32] | 32'h8;
            m_z3[c] = sd[c*96 + 64 +: 32] | 32'h10;
        end
    endtask

    // Next beat of the ideal noise sequence: sum of 4 bytes, centred, scaled, rounded, clipped
    task automatic model_beat(input int unsigned sc, output logic [NUM_CH*OUT_W-1:0] beat);
        int unsigned u;
        longint s, q, r;
        beat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_z1[c] = taus1(m_z1[c]);
            m_z2[c] = taus2(m_z2[c]);
            m_z3[c] = taus3(m_z3[c]);
            u = m_z1[c] ^ m_z2[c] ^ m_z3[c];
            s = longint'(u[7:0]) + longint'(u[15:8]) + longint'(u[23:16]) + longint'(u[31:24]) - 510;
            q = s * longint'(sc) + 128;
            r = (q >= 0) ? (q / 256) : -((-q + 255) / 256);
            if (r > C_MAXV)  r = C_MAXV;
            if (r < -C_MAXV) r = -C_MAXV;
            beat[c*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
    endtask

    task automatic observe();
        logic [NUM_CH*OUT_W-1:0] exp;
        @(negedge clk);
        if (out_valid && first_valid < 0) first_valid = iter;
        if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'(out_data), 64'(prev_data));
        end
        if (en && !(out_valid && !out_ready)) issued++;
        if (out_valid && out_ready) begin
            model_beat(32'(scale), exp);
            for (int c = 0; c < NUM_CH; c++)
                check($sformatf("beat%0d_ch%0d", acc, c),
                      64'(out_data[c*OUT_W +: OUT_W]), 64'(exp[c*OUT_W +: OUT_W]));
            acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    // Issues n URNG steps and runs until all n beats have been accepted
    task automatic run_phase(input string name, input int n, input int ready_pct,
                             input int en_pct, input bit lat);
        int budget;
        int start;
        budget      = n * 8 + 100;
        start       = acc;
        issued      = 0;
        iter        = 0;
        first_valid = -1;
        while ((acc - start) < n && iter < budget) begin
            iter++;
            out_ready = ($urandom_range(99) < 32'(ready_pct));
            en        = (issued < n) && ($urandom_range(99) < 32'(en_pct));
            observe();
            @(posedge clk); #1;
        end
        en = 1'b0;
        check({name, "_beats"}, 64'(acc - start), 64'(n));
        if (lat) check({name, "_latency"}, 64'(first_valid), 64'd5);
        check({name, "_cnt"}, 64'(sample_cnt), 64'(acc));
    endtask

    task automatic do_reset(input logic [NUM_CH*96-1:0] sd);
        seed_data = sd;
        reset     = 1'b1;
        en        = 1'($urandom_range(1));
        out_ready = 1'($urandom_range(1));
        seed_load = 1'($urandom_range(1));
        @(posedge clk); #1;
        reset     = 1'b0;
        seed_load = 1'b0;
        en        = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_cnt", 64'(sample_cnt), 64'd0);
        model_load(sd);
        acc        = 0;
        prev_stall = 1'b0;
    endtask

    logic [NUM_CH*96-1:0] seed_a, seed_b;

    initial begin
        seed_a    = {32'h44E5207C, 32'hA16FD718, 32'h7D6F5A7C,
                     32'hFFFF3434, 32'h129F8963, 32'h003110DA};
        for (int i = 0; i < NUM_CH * 3; i++) seed_b[i*32 +: 32] = $urandom;
        scale     = 16'h0100;
        seed_load = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        do_reset(seed_a);

        run_phase("main", 10000, 100, 100, 1'b1);

        scale = 16'h0000;
        run_phase("scale0", 300, 100, 100, 1'b0);
        scale = 16'hFFFF;
        run_phase("scalemax", 300, 70, 100, 1'b0);
        scale = 16'h0100;

        run_phase("backpressure", 5000, 30, 100, 1'b0);
        scale = 16'h0180;
        run_phase("gaps", 500, 60, 70, 1'b0);
        scale = 16'h0100;

        // Fill the pipeline against a blocked sink, then reload seeds
        out_ready = 1'b0;
        en        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            observe();
            @(posedge clk); #1;
        end
        check("pending_valid", 64'(out_valid), 64'd1);
        seed_data = seed_b;
        seed_load = 1'b1;
        observe();
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("load_valid", 64'(out_valid), 64'd0);
        check("load_cnt", 64'(sample_cnt), 64'(acc));
        model_load(seed_b);
        prev_stall = 1'b0;
        run_phase("reload", 200, 100, 100, 1'b1);

        // Mid-stream reset restores the original sequence
        out_ready = 1'b1;
        en        = 1'b1;
        for (int i = 0; i < 10; i++) begin
            observe();
            @(posedge clk); #1;
        end
        do_reset(seed_a);
        run_phase("restart", 200, 100, 100, 1'b1);

        do_reset('0);
        run_phase("zeroseed", 1000, 100, 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/awgn_clt_multi.md
# awgn_clt_multi

Parametrised multi-channel AWGN noise source: NUM_CH independent Tausworthe (taus88) URNGs, each feeding a 4-term central-limit summer, a runtime sigma scaler and a round/saturate stage. It produces NUM_CH signed noise samples per beat on a valid/ready stream for the LDPC channel-simulation path. It adds runtime seed reload, sigma control, configurable output width/channel count and backpressure.

## Interface
- NUM_CH, 2, number of independent noise channels (1..16)
- OUT_W, 17, signed output sample width per channel (8..24)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  request new samples; sampled each non-stalled edge
- seed_load  in  1  reload all URNG states from seed_data and flush pipeline
- seed_data  in  NUM_CH*96  channel c at [c*96 +: 96]: [31:0]=z1, [63:32]=z2, [95:64]=z3
- scale  in  16  unsigned Q8.8 sigma multiplier (0x0100 = 1.0)
- out_ready  in  1  downstream accepts beat
- out_valid  out  1  out_data holds a valid beat
- out_data  out  NUM_CH*OUT_W  channel c sample at [c*OUT_W +: OUT_W], two's complement
- sample_cnt  out  32  accepted beats (out_valid && out_ready), wraps at 2^32

## Operation
- Seed sanitisation on every load: z1|=32'h2, z2|=32'h8, z3|=32'h10 (guarantees taus88 minimum states).
- URNG step per channel (all shifts logical, 32-bit):
  - z1' = ((z1&FFFFFFFE)<<12) ^ (((z1<<13)^z1)>>19)
  - z2' = ((z2&FFFFFFF8)<<4) ^ (((z2<<2)^z2)>>25)
  - z3' = ((z3&FFFFFFF0)<<17) ^ (((z3<<3)^z3)>>11)
  - u = z1'^z2'^z3', registered in stage 0 together with the new state.
- Stage 1: S = u[7:0]+u[15:8]+u[23:16]+u[31:24] − 510; 11-bit signed, range −510..+510.
- Stage 2: P = S × {1'b0,scale}; 28-bit signed; scale sampled at this stage.
- Stage 3: R = (P + 128) >>> 8 (round half up); saturate symmetrically to ±(2^(OUT_W−1)−1); register into out_data.
- Stall = out_valid && !out_ready. When stalled, no register (URNG states, data, valids) changes.
- When not stalled: v0<=en, v1<=v0, v2<=v1, out_valid<=v2; URNG steps only when en=1. Data stages with invalid inputs still load but are ignored.
- sample_cnt increments on each edge with out_valid && out_ready.
- reset: load sanitised seed_data into all states; v0..v2, out_valid = 0; out_data = 0; sample_cnt = 0; stage data registers = 0.
- seed_load (reset low): same as reset except sample_cnt is held. It takes priority over en and over stall, so a pending unaccepted beat is dropped.

## Timing
- en sampled high at edge k (no stall) → out_valid high after edge k+3; latency 4 edges.
- en held high with out_ready=1 gives one beat per cycle; the n-th beat uses the n-th URNG step after load.
- en deasserted at edge k: the pipeline drains; the last valid beat appears after edge k+2. No URNG advance while en=0.
- out_ready low: out_valid and out_data stay stable until accepted; the beat is accepted on the first edge with out_ready=1.
- Simultaneous seed_load and en: seed_load wins. The first stepped state is derived from the new seeds at the next en edge.
- Reset mid-stream: the next edge leaves all outputs at reset values regardless of en, stall or seed_load.
- scale change takes effect on samples entering stage 2 on or after the change edge (visible at out_data after one more edge). It never alters a stalled beat.

## Test plan
- Reset with seeds z1=003110DA, z2=129F8963, z3=FFFF3434 (ch0) and 7D6F5A7C/A16FD718/44E5207C (ch1); scale=0x0100; en=1; out_ready=1. Required: out_valid rises after the 4th edge, out_data matches the C taus88+CLT model bit-exactly for 10000 beats, and sample_cnt=10000.
- Seeds all zero → sanitised to 2/8/16. Required: the generator does not lock up, and 1000 beats match the model using states 2/8/16.
- scale=0 → every valid sample = 0. Separately, scale=0xFFFF with OUT_W=8 → every sample lies in −127..127, and |S|≥1 saturates to ±127.
- Random out_ready at 30% duty over 5000 beats. Required: no beat lost or duplicated versus the model sequence, out_data is stable while stalled, and sample_cnt equals the accepted count.
- seed_load pulsed mid-stream while a beat is stalled. Required: out_valid drops next edge, the stalled beat is never accepted, the sequence restarts from the new seeds with 4-edge latency, and sample_cnt is unchanged.
- NUM_CH=4, OUT_W=12 regression, with reset asserted mid-stream for one cycle. Required: all outputs return to 0/invalid and the sequence restarts identically to the first run.
